// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// (e.g. 0xED set LEDs, 0xEE echo, 0xFF reset) over the shared clock/data
// pair using open-drain drives, then checks the device acknowledge.
// While a frame is in progress rx_inhibit tells the neighbouring receiver
// to ignore the line.
//
// Ports
//   sys_clock, reset_n        system clock (rising edge), async active-low reset
//   tx_data[7:0], tx_valid    command byte and send request
//   tx_ready                  high only when idle; accept = tx_valid & tx_ready
//   tx_done / tx_error        1-cycle pulses: acked frame / NACK or timeout
//   busy, rx_inhibit          high whenever not idle
//   ps2_clk_in, ps2_dat_in    line levels as read (asynchronous)
//   ps2_clk_oe, ps2_dat_oe    1 = pull the line low, 0 = release
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1400,
    parameter int TIMEOUT_CYCLES = 280000
) (
    input  logic       sys_clock,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    // One counter serves both the inhibit interval and the ack timeout,
    // so it is sized for the larger of the two.
    localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 2);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4,   // stop bit released; fall 11 samples the ack
        WAIT_IDLE = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      clk_sync, dat_sync;
    logic            clk_prev;
    logic            clk_s, dat_s, fall;
    logic [8:0]      shift_q;
    logic [3:0]      edge_q;
    logic [CW-1:0]   cnt_q;
    logic            dat_low_q;
    logic            done_q, err_q;
    logic            accept, active, timeout;
    logic            done_d, err_d;

    // Synchronisers reset to 1 (idle line level) so reset release never
    // produces a spurious falling edge.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_prev <= clk_sync[1];
        end
    end

    assign clk_s   = clk_sync[1];
    assign dat_s   = dat_sync[1];
    assign fall    = clk_prev & ~clk_s;
    assign accept  = tx_valid & (state_q == IDLE);
    assign active  = (state_q == REQ) || (state_q == DATA) ||
                     (state_q == STOP) || (state_q == WAIT_IDLE);
    assign timeout = TO_EN && active && (cnt_q == TO_LAST);

    // State register
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; timeout overrides any edge seen in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = INHIBIT;
            INHIBIT:   if (cnt_q == INH_LAST) state_d = REQ;
            REQ:       if (fall) state_d = DATA;
            DATA:      if (fall && edge_q == 4'd9) state_d = STOP;
            STOP:      if (fall) state_d = dat_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (clk_s && dat_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (timeout) state_d = IDLE;
    end

    // Outputs. Line drives decode from state only, so an async reset
    // releases both lines immediately.
    always_comb begin
        ps2_clk_oe = (state_q == INHIBIT);
        ps2_dat_oe = ((state_q == INHIBIT) && (cnt_q == INH_LAST)) ||
                     (state_q == REQ) ||
                     ((state_q == DATA) && dat_low_q);
        done_d     = (state_q == WAIT_IDLE) && clk_s && dat_s && !timeout;
        err_d      = timeout || ((state_q == STOP) && fall && dat_s);
    end

    // Datapath: shifter, edge counter, interval counter, pulse registers.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q   <= '0;
            edge_q    <= '0;
            cnt_q     <= '0;
            dat_low_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
            if (accept) begin
                shift_q   <= {~^tx_data, tx_data};
                edge_q    <= '0;
                dat_low_q <= 1'b0;
            end else if (fall && ((state_q == REQ) || (state_q == DATA) || (state_q == STOP))) begin
                // Host changes data after each device falling edge; the
                // device samples it on the following rising edge.
                edge_q    <= edge_q + 4'd1;
                dat_low_q <= ~shift_q[0];
                shift_q   <= {1'b0, shift_q[8:1]};
            end
            if ((state_q == IDLE) || ((state_q == INHIBIT) && (state_d == REQ)))
                cnt_q <= '0;
            else if ((state_q == INHIBIT) || (TO_EN && active))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tx_ready   = (state_q == IDLE);
    assign busy       = ~tx_ready;
    assign rx_inhibit = busy;
    assign tx_done    = done_q;
    assign tx_error   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 500;
    localparam int H   = 10;   // device half period in sys clocks (scaled-down PS/2 rate)

    logic       sys_clock = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_error, busy, rx_inhibit;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk = 1'b1, dev_dat = 1'b1;
    wire        ps2_clk_in = dev_clk & ~ps2_clk_oe;
    wire        ps2_dat_in = dev_dat & ~ps2_dat_oe;

    int n_chk = 0, n_err = 0;
    int done_cnt = 0, err_cnt = 0, frame_cnt = 0, viol = 0;
    logic done_prev = 1'b0, err_prev = 1'b0, busy_prev = 1'b0;

    logic [7:0] dv_got;
    logic       dv_par, dv_stp, dv_start, dv_ok;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clock (sys_clock), .reset_n (reset_n),
        .tx_data   (tx_data),   .tx_valid (tx_valid),
        .tx_ready  (tx_ready),  .tx_done  (tx_done),
        .tx_error  (tx_error),  .busy     (busy),
        .rx_inhibit(rx_inhibit),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 sys_clock = ~sys_clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle monitor: handshake consistency and pulse accounting.
    always @(negedge sys_clock) begin
        if (reset_n !== 1'b0 || 1'b1) begin
            if (tx_ready !== ~busy || rx_inhibit !== busy) viol++;
            if (tx_done && tx_error) viol++;
            if ((tx_done && done_prev) || (tx_error && err_prev)) viol++;
            if (tx_done) done_cnt++;
            if (tx_error) err_cnt++;
            if (busy && !busy_prev) frame_cnt++;
            done_prev = tx_done;
            err_prev  = tx_error;
            busy_prev = busy;
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge sys_clock); #1;
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge sys_clock); #1;
        tx_valid = 1'b0;
    endtask

    // Device side: waits for the host request, clocks 11 edges, samples
    // bits on rising edges, drives the ack unless nack. abort_after>0 stops
    // with the clock held low after that many falls.
    task automatic device_rx(input int abort_after, input bit nack);
        int t = 0;
        dv_ok = 1'b0; dv_got = 'x; dv_par = 1'bx; dv_stp = 1'bx; dv_start = 1'bx;
        while (!ps2_clk_oe && t < 5000) begin @(negedge sys_clock); t++; end
        while (ps2_clk_oe && t < 5000) begin @(negedge sys_clock); t++; end
        if (t >= 5000) return;
        dv_start = ps2_dat_in;
        repeat (H) @(negedge sys_clock);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && !nack) dev_dat = 1'b0;
            dev_clk = 1'b0;
            repeat (H) @(negedge sys_clock);
            if (i == abort_after) begin dv_ok = 1'b1; return; end
            dev_clk = 1'b1;
            if (i <= 8)       dv_got[i-1] = ps2_dat_in;
            else if (i == 9)  dv_par = ps2_dat_in;
            else if (i == 10) dv_stp = ps2_dat_in;
            if (i == 11) dev_dat = 1'b1;
            else repeat (H) @(negedge sys_clock);
        end
        dv_ok = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input logic exp_par, input string tag);
        int d0, e0, n;
        d0 = done_cnt; e0 = err_cnt;
        fork
            send(b);
            device_rx(0, 1'b0);
        join
        chk({tag, "_dev_ok"}, dv_ok, 1);
        chk({tag, "_start"}, dv_start, 0);
        chk({tag, "_byte"}, dv_got, b);
        chk({tag, "_parity"}, dv_par, exp_par);
        chk({tag, "_stop"}, dv_stp, 1);
        // 2-flop sync sees both lines high after 2 cycles, pulse one cycle later.
        n = 0;
        while (!tx_done && n < 20) begin @(negedge sys_clock); n++; end
        chk({tag, "_done_lat"}, n, 3);
        @(negedge sys_clock);
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
        chk({tag, "_err_cnt"}, err_cnt - e0, 0);
    endtask

    initial begin
        int d0, e0, f0, n;
        reset_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge sys_clock);
        chk("rst_outs", {tx_ready, busy, rx_inhibit, ps2_clk_oe, ps2_dat_oe, tx_done, tx_error}, 7'b1000000);
        @(posedge sys_clock); #1 reset_n = 1'b1;
        repeat (3) @(negedge sys_clock);
        chk("rst_rel_outs", {tx_ready, busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);

        // Normal frames with hand-computed odd parity
        frame(8'hED, 1'b1, "ed");
        frame(8'h00, 1'b1, "x00");
        frame(8'hFF, 1'b1, "xff");
        frame(8'h01, 1'b0, "x01");

        // NACK: data left high at fall 11
        d0 = done_cnt; e0 = err_cnt;
        fork
            send(8'hA5);
            device_rx(0, 1'b1);
            begin
                int w = 0;
                while (!tx_error && w < 3000) begin @(negedge sys_clock); w++; end
                chk("nack_pulse", tx_error, 1);
                @(negedge sys_clock);
                chk("nack_after", {ps2_clk_oe, ps2_dat_oe, tx_ready}, 3'b001);
            end
        join
        repeat (5) @(negedge sys_clock);
        chk("nack_byte", dv_got, 8'hA5);
        chk("nack_parity", dv_par, 1);
        chk("nack_err_cnt", err_cnt - e0, 1);
        chk("nack_done_cnt", done_cnt - d0, 0);

        // Timeout: device never clocks
        d0 = done_cnt; e0 = err_cnt;
        send(8'h55);
        n = 0;
        while (!ps2_clk_oe && n < 100) begin @(negedge sys_clock); n++; end
        while (ps2_clk_oe && n < 100) begin @(negedge sys_clock); n++; end
        chk("to_req_start", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
        n = 0;
        while (!tx_error && n < 1000) begin @(negedge sys_clock); n++; end
        chk("to_latency", n, 500);
        chk("to_outs", {ps2_clk_oe, ps2_dat_oe, tx_ready, tx_done}, 4'b0010);
        repeat (3) @(negedge sys_clock);
        chk("to_err_cnt", err_cnt - e0, 1);
        chk("to_done_cnt", done_cnt - d0, 0);

        // Reset during the 5th data bit (0x0F: bit4=0, so data is pulled low)
        d0 = done_cnt; e0 = err_cnt;
        fork
            send(8'h0F);
            device_rx(5, 1'b0);
        join
        chk("rstmid_pre", {busy, ps2_dat_oe}, 2'b11);
        #2 reset_n = 1'b0;
        #1 chk("rstmid_async", {ps2_clk_oe, ps2_dat_oe, busy, tx_ready}, 4'b0001);
        dev_clk = 1'b1;
        repeat (3) @(negedge sys_clock);
        @(posedge sys_clock); #1 reset_n = 1'b1;
        repeat (50) @(negedge sys_clock);
        chk("rstmid_ready", tx_ready, 1);
        chk("rstmid_pulses", {done_cnt - d0, err_cnt - e0}, 64'd0);

        // tx_valid held with changing data: one frame, original byte
        d0 = done_cnt; e0 = err_cnt; f0 = frame_cnt;
        fork
            begin
                int w = 0;
                @(posedge sys_clock); #1;
                tx_data = 8'h96; tx_valid = 1'b1;
                @(posedge sys_clock); #1;
                tx_data = 8'h42;
                while (!tx_done && w < 2000) begin @(negedge sys_clock); w++; end
                #1 tx_valid = 1'b0;
            end
            device_rx(0, 1'b0);
        join
        repeat (100) @(negedge sys_clock);
        chk("hold_byte", dv_got, 8'h96);
        chk("hold_parity", dv_par, 1);
        chk("hold_frames", frame_cnt - f0, 1);
        chk("hold_done_cnt", done_cnt - d0, 1);
        chk("hold_err_cnt", err_cnt - e0, 0);

        chk("ready_busy_viol", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
